// File: rtl/spi_multi_stream_seq.sv
// spi_multi_stream_seq: sequences per-channel SPI command/header-hunt/payload fetches
// for NUM_CH streams, with enable mask, hunt timeout/retry/skip and ping-pong banks.
`default_nettype none

module spi_multi_stream_seq #(
   parameter int                  NUM_CH     = 2,
   parameter logic [NUM_CH*8-1:0] CMD_TABLE  = {8'hAA, 8'hFA},
   parameter logic [NUM_CH*8-1:0] HDR_TABLE  = {8'hAA, 8'hFA},
   parameter int                  HUNT_LIMIT = 64,
   parameter int                  MAX_RETRY  = 2,
   localparam int                 CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK_50,
   input  logic              reset,
   input  logic              start,
   input  logic              frame_done,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic [NUM_CH-1:0] ch_full,
   output logic [7:0]        tx_byte,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [7:0]        rx_byte,
   input  logic              rx_valid,
   output logic [NUM_CH-1:0] wr_en,
   output logic [7:0]        wr_data,
   output logic [NUM_CH-1:0] bank_sel,
   output logic [CW-1:0]     cur_ch,
   output logic              busy,
   output logic [NUM_CH-1:0] timeout_err
);

   localparam int HW = $clog2(HUNT_LIMIT + 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SELECT  = 3'd1,
      REQ     = 3'd2,
      PARSE   = 3'd3,
      RECEIVE = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t            state;
   logic [NUM_CH-1:0] mask;
   logic [CW:0]       scan;     // one bit wider than cur_ch so "past the last channel" is representable
   logic [HW-1:0]     hunt;
   logic [RW-1:0]     retry;

   logic              found;
   logic [CW-1:0]     pick;
   logic [HW-1:0]     hunt_next;
   logic [CW-1:0]     cur_ch_next;
   logic [CW:0]       scan_next;
   logic [7:0]        cmd_pick;
   logic [7:0]        cmd_cur;
   logic [7:0]        hdr_cur;

   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(scan))) begin
            found = 1'b1;
            pick  = CW'(i);
         end
      end
   end

   assign hunt_next   = hunt + 1'b1;
   assign scan_next   = {1'b0, cur_ch} + 1'b1;
   // cur_ch saturates on the last channel; scan alone carries the end-of-frame condition
   assign cur_ch_next = (cur_ch == CW'(NUM_CH - 1)) ? cur_ch : cur_ch + 1'b1;
   assign cmd_pick    = CMD_TABLE[8*int'(pick) +: 8];
   assign cmd_cur     = CMD_TABLE[8*int'(cur_ch) +: 8];
   assign hdr_cur     = HDR_TABLE[8*int'(cur_ch) +: 8];

   always_ff @(posedge CLK_50) begin
      if (reset) begin
         state       <= IDLE;
         mask        <= '0;
         scan        <= '0;
         hunt        <= '0;
         retry       <= '0;
         tx_byte     <= '0;
         tx_valid    <= 1'b0;
         wr_en       <= '0;
         wr_data     <= '0;
         bank_sel    <= '0;
         cur_ch      <= '0;
         busy        <= 1'b0;
         timeout_err <= '0;
      end else begin
         wr_en <= '0;
         case (state)
            IDLE: begin
               if (start || frame_done) begin
                  mask        <= ch_enable;
                  timeout_err <= '0;
                  cur_ch      <= '0;
                  scan        <= '0;
                  busy        <= 1'b1;
                  state       <= SELECT;
               end
            end
            SELECT: begin
               if (!found) begin
                  state <= DONE;
               end else begin
                  cur_ch   <= pick;
                  scan     <= {1'b0, pick};
                  retry    <= '0;
                  hunt     <= '0;
                  tx_byte  <= cmd_pick;
                  tx_valid <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (tx_valid && tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= PARSE;
               end
            end
            PARSE: begin
               if (rx_valid) begin
                  hunt <= hunt_next;
                  if (rx_byte == hdr_cur) begin
                     state <= RECEIVE;
                  end else if (hunt_next == HW'(HUNT_LIMIT)) begin
                     if (retry < RW'(MAX_RETRY)) begin
                        retry    <= retry + 1'b1;
                        hunt     <= '0;
                        tx_byte  <= cmd_cur;
                        tx_valid <= 1'b1;
                        state    <= REQ;
                     end else begin
                        timeout_err[cur_ch] <= 1'b1;
                        cur_ch              <= cur_ch_next;
                        scan                <= scan_next;
                        state               <= SELECT;
                     end
                  end
               end
            end
            RECEIVE: begin
               // full wins over a same-cycle byte: that byte is dropped
               if (ch_full[cur_ch]) begin
                  bank_sel[cur_ch] <= ~bank_sel[cur_ch];
                  cur_ch           <= cur_ch_next;
                  scan             <= scan_next;
                  state            <= SELECT;
               end else if (rx_valid) begin
                  wr_en[cur_ch] <= 1'b1;
                  wr_data       <= rx_byte;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy     <= 1'b0;
               tx_valid <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_multi_stream_seq.sv
// Directed self-checking bench for spi_multi_stream_seq (2 channels: ch0 AA/AA, ch1 FA/FA).
`default_nettype none

module tb_spi_multi_stream_seq;

   logic       CLK_50 = 1'b0;
   logic       reset, start, frame_done, tx_ready, rx_valid;
   logic [1:0] ch_enable, ch_full;
   logic [7:0] rx_byte;
   logic [7:0] tx_byte, wr_data;
   logic       tx_valid, busy;
   logic [1:0] wr_en, bank_sel, timeout_err;
   logic       cur_ch;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] txlog[$];
   logic [7:0] wlog0[$];
   logic [7:0] wlog1[$];

   always #10 CLK_50 = ~CLK_50;

   spi_multi_stream_seq #(
      .NUM_CH(2), .CMD_TABLE(16'hFAAA), .HDR_TABLE(16'hFAAA),
      .HUNT_LIMIT(64), .MAX_RETRY(2)
   ) dut (
      .CLK_50(CLK_50), .reset(reset), .start(start), .frame_done(frame_done),
      .ch_enable(ch_enable), .ch_full(ch_full), .tx_byte(tx_byte), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_byte(rx_byte), .rx_valid(rx_valid), .wr_en(wr_en),
      .wr_data(wr_data), .bank_sel(bank_sel), .cur_ch(cur_ch), .busy(busy),
      .timeout_err(timeout_err)
   );

   always @(negedge CLK_50) begin
      if (tx_valid && tx_ready) txlog.push_back(tx_byte);
      if (wr_en[0]) wlog0.push_back(wr_data);
      if (wr_en[1]) wlog1.push_back(wr_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_50);
      #1;
   endtask

   task automatic wait_req(input string tag, input logic [7:0] cmd);
      int n = 0;
      while (!tx_valid && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_req_seen"}, 32'(tx_valid), 32'd1);
      check({tag, "_cmd"}, 32'(tx_byte), 32'(cmd));
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic fill(input int ch);
      ch_full[ch] = 1'b1;
      tick();
      ch_full[ch] = 1'b0;
   endtask

   task automatic run_channel(input string tag, input int ch, input int njunk,
                              input int npay, input logic [7:0] base);
      logic [7:0] code;
      code = (ch == 0) ? 8'hAA : 8'hFA;
      wait_req(tag, code);
      for (int i = 0; i < njunk; i++) send_rx(8'(i));
      send_rx(code);
      for (int i = 0; i < npay; i++) send_rx(base + 8'(i));
      fill(ch);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic clear_logs();
      txlog.delete();
      wlog0.delete();
      wlog1.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; frame_done = 1'b0; tx_ready = 1'b0;
      rx_valid = 1'b0; rx_byte = 8'h00; ch_enable = 2'b00; ch_full = 2'b00;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_tx_valid", 32'(tx_valid), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_bank", 32'(bank_sel), 0);
      check("rst_terr", 32'(timeout_err), 0);
      check("rst_cur_ch", 32'(cur_ch), 0);
      reset = 1'b0;
      tick();

      // both channels, junk before ch0 header
      clear_logs();
      ch_enable = 2'b11;
      pulse_start();
      check("t1_busy", 32'(busy), 1);
      check("t1_lat1", 32'(tx_valid), 0);
      tick();
      check("t1_lat2", 32'(tx_valid), 1);
      run_channel("t1c0", 0, 3, 5, 8'h10);
      run_channel("t1c1", 1, 0, 4, 8'h20);
      wait_idle("t1");
      check("t1_ntx", txlog.size(), 2);
      check("t1_tx0", 32'(txlog[0]), 32'hAA);
      check("t1_tx1", 32'(txlog[1]), 32'hFA);
      check("t1_nw0", wlog0.size(), 5);
      check("t1_nw1", wlog1.size(), 4);
      for (int i = 0; i < 5; i++) check("t1_w0", 32'(wlog0[i]), 32'h10 + i);
      for (int i = 0; i < 4; i++) check("t1_w1", 32'(wlog1[i]), 32'h20 + i);
      check("t1_bank", 32'(bank_sel), 32'b11);
      check("t1_terr", 32'(timeout_err), 0);

      // only channel 1 enabled, triggered by frame_done
      clear_logs();
      ch_enable  = 2'b10;
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      run_channel("t2c1", 1, 0, 2, 8'h30);
      wait_idle("t2");
      check("t2_ntx", txlog.size(), 1);
      check("t2_tx0", 32'(txlog[0]), 32'hFA);
      check("t2_cur_ch", 32'(cur_ch), 1);
      check("t2_bank", 32'(bank_sel), 32'b01);
      check("t2_nw0", wlog0.size(), 0);
      check("t2_nw1", wlog1.size(), 2);

      // ch0 never answers: 3 requests of 64 bytes, then skipped
      clear_logs();
      ch_enable = 2'b11;
      pulse_start();
      for (int r = 0; r < 3; r++) begin
         wait_req("t3c0", 8'hAA);
         for (int i = 0; i < 64; i++) send_rx(8'(i));
      end
      run_channel("t3c1", 1, 0, 1, 8'h40);
      wait_idle("t3");
      check("t3_ntx", txlog.size(), 4);
      check("t3_tx2", 32'(txlog[2]), 32'hAA);
      check("t3_tx3", 32'(txlog[3]), 32'hFA);
      check("t3_terr", 32'(timeout_err), 32'b01);
      check("t3_bank", 32'(bank_sel), 32'b11);
      check("t3_nw0", wlog0.size(), 0);
      check("t3_w1", 32'(wlog1[0]), 32'h40);

      // reset in the middle of ch0 payload
      clear_logs();
      pulse_start();
      check("t6_terr_clr", 32'(timeout_err), 0);
      wait_req("t6c0", 8'hAA);
      send_rx(8'hAA);
      send_rx(8'h51);
      send_rx(8'h52);
      reset = 1'b1;
      tick();
      check("t6_wr_en", 32'(wr_en), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_bank", 32'(bank_sel), 0);
      check("t6_terr", 32'(timeout_err), 0);
      check("t6_tx_valid", 32'(tx_valid), 0);
      check("t6_nw0", wlog0.size(), 2);
      reset = 1'b0;
      tick();

      // simultaneous triggers, then a start while busy
      clear_logs();
      start = 1'b1; frame_done = 1'b1;
      tick();
      start = 1'b0; frame_done = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      run_channel("t4c0", 0, 0, 0, 8'h00);
      run_channel("t4c1", 1, 0, 0, 8'h00);
      wait_idle("t4");
      repeat (5) tick();
      check("t4_busy_after", 32'(busy), 0);
      check("t4_tx_valid_after", 32'(tx_valid), 0);
      check("t4_ntx", txlog.size(), 2);
      check("t4_bank", 32'(bank_sel), 32'b11);

      // ch_full[0] already high when the header matches
      clear_logs();
      pulse_start();
      wait_req("t5c0", 8'hAA);
      ch_full[0] = 1'b1;
      send_rx(8'hAA);
      send_rx(8'h61);
      ch_full[0] = 1'b0;
      run_channel("t5c1", 1, 0, 1, 8'h70);
      wait_idle("t5");
      check("t5_nw0", wlog0.size(), 0);
      check("t5_nw1", wlog1.size(), 1);
      check("t5_bank", 32'(bank_sel), 32'b00);
      check("t5_ntx", txlog.size(), 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spi_multi_stream_seq.md
Name: spi_multi_stream_seq

Overview:
- Parametrised successor to the single video/audio data FSM: sequences byte-level SPI fetches for NUM_CH streams (e.g. video, audio, subtitles) in ascending channel order per frame.
- For each enabled channel: send that channel's command byte, hunt for its header byte, then route payload bytes to that channel's buffer until the buffer reports full.
- Adds a per-channel enable mask, a header-hunt timeout with bounded retry and skip, and per-channel ping-pong bank select.
- Sits between the top-level control (start/frame_done) and the byte-wide SPI master.

Parameters:
- NUM_CH, 2, number of stream channels (1..8).
- CMD_TABLE, {8'hAA,8'hFA}, packed NUM_CH*8 command bytes; channel c uses bits [8c+7:8c].
- HDR_TABLE, {8'hAA,8'hFA}, packed NUM_CH*8 header bytes expected on MISO for channel c.
- HUNT_LIMIT, 64, rx bytes allowed in PARSE before a timeout is declared.
- MAX_RETRY, 2, re-requests per channel after timeout before the channel is skipped.

Ports:
- CLK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begin a frame fetch
- frame_done  in  1  one-cycle pulse, display consumed a frame
- ch_enable  in  NUM_CH  per-channel enable mask, sampled in IDLE on the trigger
- ch_full  in  NUM_CH  buffer-full flag per channel
- tx_byte  out  8  command byte to SPI master
- tx_valid  out  1  command valid
- tx_ready  in  1  SPI master accepts tx_byte (transfer fires when tx_valid&tx_ready)
- rx_byte  in  8  byte received from MISO
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- wr_en  out  NUM_CH  one-hot write strobe to channel buffers
- wr_data  out  8  payload byte (registered copy of rx_byte)
- bank_sel  out  NUM_CH  per-channel ping-pong bank select
- cur_ch  out  $clog2(NUM_CH) or 1  active channel index
- busy  out  1  high whenever state != IDLE
- timeout_err  out  NUM_CH  sticky per-channel skip flags, cleared on the next trigger

Behaviour:
- All outputs registered.
- Reset values:
  - state = IDLE; every output = 0.
  - Internal retry counter = 0; hunt counter = 0; latched mask = 0.
- Reset takes effect in any state, including mid-transfer; any pending tx_valid drops on the next cycle.
- States: IDLE, SELECT, REQ, PARSE, RECEIVE, DONE.
- IDLE:
  - On (start | frame_done): latch ch_enable, clear timeout_err, set cur_ch = 0, go to SELECT.
  - If both pulses arrive in the same cycle, that counts as one trigger.
  - A trigger while busy is ignored.
- SELECT (1 cycle):
  - If no latched-enabled channel has index >= cur_ch, go to DONE.
  - Otherwise set cur_ch to the lowest such index, clear retry and hunt counters, and go to REQ.
- REQ:
  - tx_valid = 1 and tx_byte = CMD_TABLE[cur_ch].
  - On the tx_valid&tx_ready cycle: tx_valid drops the next cycle, go to PARSE.
- PARSE:
  - Each rx_valid increments the hunt counter.
  - rx_byte == HDR_TABLE[cur_ch]: go to RECEIVE; the header byte is not written.
  - Hunt counter reaches HUNT_LIMIT without a match:
    - If retry < MAX_RETRY: retry += 1, clear hunt counter, go to REQ.
    - Else: set timeout_err[cur_ch], cur_ch += 1, go to SELECT. bank_sel is unchanged.
- RECEIVE:
  - Each rx_valid produces, one cycle later, wr_en[cur_ch] = 1 (single cycle) with wr_data = that byte.
  - When ch_full[cur_ch] is seen high, which may happen before or on an rx_valid cycle:
    - No write is issued for that cycle's byte.
    - Toggle bank_sel[cur_ch], cur_ch += 1, go to SELECT.
- DONE (1 cycle): return to IDLE; busy drops on entry to IDLE.
- ch_full already high on entry to RECEIVE: zero writes, bank toggles, channel completes.
- cur_ch after the last channel: the SELECT test fails and the FSM goes to DONE. cur_ch must not wrap into a re-fetch.
- Counter widths: hunt = $clog2(HUNT_LIMIT+1); retry = $clog2(MAX_RETRY+1). No overflow is possible.
- Latency from trigger to first tx_valid = 2 cycles (IDLE→SELECT→REQ).

Test Plan:
- NUM_CH=2, mask=2'b11. start; header 8'hAA after 3 junk bytes; 5 payload bytes then ch_full[0]; header 8'hFA; 4 bytes then ch_full[1].
  - Expect tx_byte AA then FA; wr_en[0] ×5, wr_en[1] ×4 with matching data; bank_sel=2'b11; busy low after DONE.
- Mask=2'b10. frame_done.
  - Expect only FA sent, cur_ch=1, bank_sel[0] untouched.
- Channel 0 never sends a header, HUNT_LIMIT=64, MAX_RETRY=2.
  - Expect 3 AA requests, each followed by 64 rx bytes; then timeout_err=2'b01; channel 1 proceeds normally.
- start and frame_done in the same cycle, then start again while busy.
  - Expect exactly one fetch sequence.
- reset asserted mid-RECEIVE after 2 writes.
  - Next cycle: state IDLE, wr_en=0, bank_sel=0, busy=0, timeout_err=0.
- ch_full[0] already high when the header matches.
  - Expect 0 writes to channel 0, bank_sel[0] toggles, move to channel 1.
